// File: rtl/mem_arb_pkg.sv
// Shared types, constants and address mapping for the memory bus arbiter.
package mem_arb_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned ADDR_W = 32;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RESP = 1'b1;

  typedef logic port_idx_t;

  localparam logic [ADDR_W-1:0] DEF_PRINT_ADR_0 = 32'h8000_0064;
  localparam logic [ADDR_W-1:0] DEF_PRINT_ADR_1 = 32'h8000_0000;

  // Folds a byte address onto the memory: bit 31 lands on the top memory bit,
  // bits between it and the low field alias away.
  function automatic logic [ADDR_W-1:0] map_mem_adr(input logic [ADDR_W-1:0] addr,
                                                    input int unsigned adr_len);
    logic [ADDR_W-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < ADDR_W - 1; i++) begin
      if (i < adr_len - 1) res[5'(i)] = addr[5'(i)];
    end
    res[5'(adr_len - 1)] = addr[ADDR_W-1];
    return res;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr.sv
// Combinational two-way round-robin pick; rr_ptr breaks ties.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_idx_t  rr_ptr,
  output logic [1:0] grant,
  output port_idx_t  winner
);

  always_comb begin
    grant  = 2'b00;
    winner = 1'b0;
    case (req)
      2'b01: begin
        grant  = 2'b01;
        winner = 1'b0;
      end
      2'b10: begin
        grant  = 2'b10;
        winner = 1'b1;
      end
      2'b11: begin
        winner = rr_ptr;
        grant  = rr_ptr ? 2'b10 : 2'b01;
      end
      default: begin
        grant  = 2'b00;
        winner = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-port arbiter for the single-port data memory with print MMIO capture.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned       ADR_LEN     = 20,
  parameter logic [ADDR_W-1:0] PRINT_ADR_0 = DEF_PRINT_ADR_0,
  parameter logic [ADDR_W-1:0] PRINT_ADR_1 = DEF_PRINT_ADR_1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                m0_req,
  input  logic                m0_we,
  input  logic [ADDR_W-1:0]   m0_addr,
  input  logic [DATA_W-1:0]   m0_wdata,
  output logic                m0_gnt,
  output logic                m0_rvalid,
  output logic [DATA_W-1:0]   m0_rdata,
  input  logic                m1_req,
  input  logic                m1_we,
  input  logic [ADDR_W-1:0]   m1_addr,
  input  logic [DATA_W-1:0]   m1_wdata,
  output logic                m1_gnt,
  output logic                m1_rvalid,
  output logic [DATA_W-1:0]   m1_rdata,
  output logic                mem_en,
  output logic                mem_wen,
  output logic [ADR_LEN-1:0]  mem_adr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [DATA_W-1:0]   disp_data,
  output logic                disp_strobe
);

  logic [0:0]        state;
  logic [0:0]        state_nxt;
  port_idx_t         rr_ptr;
  logic              mmio_q;
  logic [1:0]        rvalid_q;
  logic [DATA_W-1:0] hold0;
  logic [DATA_W-1:0] hold1;
  logic [DATA_W-1:0] disp_q;
  logic              strobe_q;

  logic [1:0]        arb_grant;
  port_idx_t         winner;
  logic              take;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              is_print;
  logic [DATA_W-1:0] resp_src;

  rr_arbiter2 u_arb (
    .req    ({m1_req, m0_req}),
    .rr_ptr (rr_ptr),
    .grant  (arb_grant),
    .winner (winner)
  );

  // Next state, grant and memory-side strobes; grants are withheld in reset and RESP.
  always_comb begin
    state_nxt = state;
    sel_we    = winner ? m1_we    : m0_we;
    sel_addr  = winner ? m1_addr  : m0_addr;
    sel_wdata = winner ? m1_wdata : m0_wdata;
    is_print  = (sel_addr == PRINT_ADR_0) || (sel_addr == PRINT_ADR_1);
    take      = (state == ST_IDLE) && rst_n && (arb_grant != 2'b00);
    m0_gnt    = take & arb_grant[0];
    m1_gnt    = take & arb_grant[1];
    mem_en    = take & ~is_print;
    mem_wen   = take & sel_we & ~is_print;
    mem_adr   = take ? ADR_LEN'(map_mem_adr(sel_addr, ADR_LEN)) : '0;
    mem_wdata = take ? sel_wdata : '0;
    if (state == ST_RESP) begin
      state_nxt = ST_IDLE;
    end else if (take && !sel_we) begin
      state_nxt = ST_RESP;
    end
  end

  // Response data is live during RESP and held afterwards until the next response.
  always_comb begin
    resp_src = mmio_q ? disp_q : mem_rdata;
    m0_rdata = rvalid_q[0] ? resp_src : hold0;
    m1_rdata = rvalid_q[1] ? resp_src : hold1;
  end

  assign m0_rvalid   = rvalid_q[0];
  assign m1_rvalid   = rvalid_q[1];
  assign disp_data   = disp_q;
  assign disp_strobe = strobe_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rr_ptr   <= 1'b0;
      mmio_q   <= 1'b0;
      rvalid_q <= 2'b00;
      hold0    <= '0;
      hold1    <= '0;
      disp_q   <= '0;
      strobe_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      rvalid_q <= 2'b00;
      strobe_q <= 1'b0;
      if (take) begin
        rr_ptr <= ~winner;
      end
      if (take && !sel_we) begin
        mmio_q           <= is_print;
        rvalid_q[winner] <= 1'b1;
      end
      if (take && sel_we && is_print) begin
        disp_q   <= sel_wdata;
        strobe_q <= 1'b1;
      end
      if (rvalid_q[0]) hold0 <= resp_src;
      if (rvalid_q[1]) hold1 <= resp_src;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: grants, reads, round-robin, print MMIO, reset.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        mem_en, mem_wen;
  logic [19:0] mem_adr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [31:0] disp_data;
  logic        disp_strobe;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_adr(mem_adr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .disp_data(disp_data), .disp_strobe(disp_strobe)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010; m0_wdata = '0;
    m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
    mem_rdata = '0;

    // reset held with a pending request
    tick(); tick();
    chk("rst_m0_gnt", 32'(m0_gnt), 0);
    chk("rst_m1_gnt", 32'(m1_gnt), 0);
    chk("rst_m0_rvalid", 32'(m0_rvalid), 0);
    chk("rst_m1_rvalid", 32'(m1_rvalid), 0);
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_strobe", 32'(disp_strobe), 0);
    chk("rst_disp", disp_data, 0);

    // single read, cycle 0
    rst_n = 1'b1;
    #1;
    chk("rd_m0_gnt", 32'(m0_gnt), 1);
    chk("rd_mem_en", 32'(mem_en), 1);
    chk("rd_mem_wen", 32'(mem_wen), 0);
    chk("rd_mem_adr", 32'(mem_adr), 32'h10);

    // cycle 1: response; m1 write waits
    tick();
    m0_req = 1'b0; mem_rdata = 32'hDEAD_BEEF;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0020; m1_wdata = 32'h5;
    #1;
    chk("rd_m0_rvalid", 32'(m0_rvalid), 1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("resp_m0_gnt", 32'(m0_gnt), 0);
    chk("resp_m1_gnt", 32'(m1_gnt), 0);
    chk("resp_m1_rvalid", 32'(m1_rvalid), 0);

    // cycle 2: port 1 granted after RESP, m0 data held
    tick();
    mem_rdata = 32'h1111_1111;
    #1;
    chk("after_rd_m1_gnt", 32'(m1_gnt), 1);
    chk("after_rd_mem_wen", 32'(mem_wen), 1);
    chk("after_rd_mem_adr", 32'(mem_adr), 32'h20);
    chk("after_rd_wdata", mem_wdata, 32'h5);
    chk("hold_m0_rvalid", 32'(m0_rvalid), 0);
    chk("hold_m0_rdata", m0_rdata, 32'hDEAD_BEEF);

    // contention: both write continuously, grants alternate starting at port 0
    tick();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0100; m0_wdata = 32'hA;
    m1_addr = 32'h0000_0200; m1_wdata = 32'hB;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_m0_gnt", 32'(m0_gnt), 32'((i % 2) == 0));
      chk("rr_m1_gnt", 32'(m1_gnt), 32'((i % 2) == 1));
      chk("rr_mem_adr", 32'(mem_adr), ((i % 2) == 0) ? 32'h100 : 32'h200);
      tick();
    end

    // print write by port 1
    m0_req = 1'b0;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h8000_0064; m1_wdata = 32'h2A;
    #1;
    chk("pw_m1_gnt", 32'(m1_gnt), 1);
    chk("pw_mem_en", 32'(mem_en), 0);
    chk("pw_mem_wen", 32'(mem_wen), 0);
    chk("pw_strobe_early", 32'(disp_strobe), 0);
    tick();
    m1_req = 1'b0;
    m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h8000_0000;
    #1;
    chk("pw_disp", disp_data, 32'h2A);
    chk("pw_strobe", 32'(disp_strobe), 1);
    chk("pr_m0_gnt", 32'(m0_gnt), 1);
    chk("pr_mem_en", 32'(mem_en), 0);

    // print read-back
    tick();
    m0_req = 1'b0;
    #1;
    chk("pr_m0_rvalid", 32'(m0_rvalid), 1);
    chk("pr_m0_rdata", m0_rdata, 32'h2A);
    chk("pr_strobe_gone", 32'(disp_strobe), 0);

    // address aliasing
    tick();
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h7FF8_0100; m0_wdata = 32'h3;
    #1;
    chk("wrap_low_adr", 32'(mem_adr), 32'h0_0100);
    chk("wrap_low_en", 32'(mem_en), 1);
    tick();
    m0_addr = 32'h8000_0100;
    #1;
    chk("wrap_hi_adr", 32'(mem_adr), 32'h8_0100);
    chk("wrap_hi_en", 32'(mem_en), 1);

    // reset while in RESP
    tick();
    m0_we = 1'b0; m0_addr = 32'h0000_0044;
    #1;
    chk("rr_rd_m0_gnt", 32'(m0_gnt), 1);
    tick();
    rst_n = 1'b0;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0300;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0400;
    #1;
    chk("rr_rst_m0_rvalid", 32'(m0_rvalid), 0);
    chk("rr_rst_m1_rvalid", 32'(m1_rvalid), 0);
    tick(); tick();
    rst_n = 1'b1;
    #1;
    chk("post_rst_m0_gnt", 32'(m0_gnt), 1);
    chk("post_rst_m1_gnt", 32'(m1_gnt), 0);
    chk("post_rst_m0_rvalid", 32'(m0_rvalid), 0);
    tick();
    #1;
    chk("post_rst_next_m1_gnt", 32'(m1_gnt), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
